// File: rtl/cortez_network_top.sv
// Wishbone-pipelined register pool and sequential single-MAC inference engine for a
// small Q2.5 MLP classifier, with argmax LEDs and a scanned seven-segment debug display.
module cortez_network_top #(
    parameter int          DATA_WIDTH      = 8,
    parameter int          FRAC_BITS       = 5,
    parameter int          NUM_INPUTS      = 9,
    parameter int          NUM_HL_NODES    = 4,
    parameter int          NUM_OL_NODES    = 3,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          SS_REFRESH_BITS = 16
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    CYC,
    input  logic                    STB,
    input  logic                    WE,
    input  logic [31:0]             ADDR,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] SEL,
    output logic                    STALL,
    output logic                    ACK,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    ERR,
    output logic [3:0]              SS_ANODES,
    output logic [7:0]              SS_SEGMENTS,
    output logic [7:0]              LEDS
);
    localparam int DW       = DATA_WIDTH;
    localparam int AW       = 7;
    localparam int I_CTRL   = 0;
    localparam int I_STATUS = 1;
    localparam int I_DBUG   = 2;
    localparam int I_GRID   = 6;
    localparam int I_GAP    = I_GRID + NUM_INPUTS;
    localparam int I_HLW    = 16;
    localparam int I_HLB    = I_HLW + NUM_INPUTS * NUM_HL_NODES;
    localparam int I_OLW    = I_HLB + NUM_HL_NODES;
    localparam int I_OLB    = I_OLW + NUM_OL_NODES * NUM_HL_NODES;
    localparam int I_RES    = I_OLB + NUM_OL_NODES;
    localparam int I_END    = I_RES + NUM_OL_NODES;
    localparam logic signed [2*DW:0] SMAX = (2*DW+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [2*DW:0] SMIN = -SMAX - 1;

    typedef enum logic [2:0] {S_IDLE, S_HL_MAC, S_HL_FIN, S_OL_MAC, S_OL_FIN} state_t;

    state_t                  state_q;
    logic [2:0]              node_q;
    logic [3:0]              idx_q;
    logic signed [2*DW-1:0]  acc_q;
    logic                    busy_q, done_q;
    logic [DW-1:0]           regs_q   [0:I_END-1];
    logic [DW-1:0]           hidden_q [0:NUM_HL_NODES-1];
    logic [DW-1:0]           res_q    [0:NUM_OL_NODES-1];
    logic                    ack_q, err_q;
    logic [DW-1:0]           rdata_q;
    logic [SS_REFRESH_BITS-1:0] cnt_q;
    logic [3:0]              anodes_q;
    logic [7:0]              segs_q;

    logic [9:0]    off;
    logic [AW-1:0] off7;
    logic          req, hit, reg_we, start, writable;
    logic [DW-1:0] rd_val;
    logic          unused_addr;

    assign off         = ADDR[11:2];
    assign off7        = off[AW-1:0];
    assign unused_addr = ^ADDR[1:0];
    assign req         = CYC & STB;
    assign hit = (ADDR[31:12] == BASE_ADDR[31:12]) && (int'(off) < I_END)
                 && !((int'(off) >= I_GAP) && (int'(off) < I_HLW));
    // Model parameters are frozen while the engine runs; scratch registers never are.
    assign writable = ((int'(off) >= I_DBUG) && (int'(off) < I_GRID))
                      || (!busy_q && (int'(off) >= I_GRID) && (int'(off) < I_RES));
    assign reg_we = req & hit & WE & SEL[0] & writable;
    assign start  = req & hit & WE & SEL[0] & (int'(off) == I_CTRL) & WDATA[1];

    always_comb begin
        rd_val = regs_q[off7];
        if (int'(off) == I_STATUS) rd_val = {{(DW-2){1'b0}}, done_q, busy_q};
        for (int k = 0; k < NUM_OL_NODES; k++)
            if (int'(off) == I_RES + k) rd_val = res_q[k];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < I_END; i++) regs_q[i] <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (reg_we) regs_q[off7] <= WDATA;
            ack_q   <= req & hit;
            err_q   <= req & ~hit;
            rdata_q <= (req & hit) ? rd_val : '0;
        end
    end

    // MAC operand and bias selection for the current engine step.
    logic [DW-1:0]          mac_w, mac_x, bias;
    logic signed [2*DW-1:0] prod, acc_sum;
    logic signed [2*DW:0]   fin_sum;
    logic [DW-1:0]          sat;

    always_comb begin
        mac_w = '0;
        mac_x = '0;
        bias  = '0;
        case (state_q)
            S_HL_MAC: begin
                mac_w = regs_q[AW'(I_HLW + int'(node_q) * NUM_INPUTS + int'(idx_q))];
                mac_x = regs_q[AW'(I_GRID + int'(idx_q))];
            end
            S_OL_MAC: begin
                mac_w = regs_q[AW'(I_OLW + int'(node_q) * NUM_HL_NODES + int'(idx_q))];
                mac_x = hidden_q[idx_q];
            end
            S_HL_FIN: bias = regs_q[AW'(I_HLB + int'(node_q))];
            S_OL_FIN: bias = regs_q[AW'(I_OLB + int'(node_q))];
            default: ;
        endcase
    end

    assign prod    = $signed(mac_w) * $signed(mac_x);
    assign acc_sum = acc_q + (prod >>> FRAC_BITS);
    assign fin_sum = {acc_q[2*DW-1], acc_q} + {{(DW+1){bias[DW-1]}}, bias};

    always_comb begin
        if (fin_sum > SMAX)      sat = {1'b0, {(DW-1){1'b1}}};
        else if (fin_sum < SMIN) sat = {1'b1, {(DW-1){1'b0}}};
        else                     sat = fin_sum[DW-1:0];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            node_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int n = 0; n < NUM_HL_NODES; n++) hidden_q[n] <= '0;
            for (int k = 0; k < NUM_OL_NODES; k++) res_q[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_HL_MAC;
                    node_q  <= '0;
                    idx_q   <= '0;
                    acc_q   <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                S_HL_MAC: begin
                    acc_q <= acc_sum;
                    idx_q <= (int'(idx_q) == NUM_INPUTS - 1) ? '0 : idx_q + 4'd1;
                    if (int'(idx_q) == NUM_INPUTS - 1) state_q <= S_HL_FIN;
                end
                S_HL_FIN: begin
                    hidden_q[node_q] <= sat[DW-1] ? '0 : sat;
                    acc_q   <= '0;
                    node_q  <= (int'(node_q) == NUM_HL_NODES - 1) ? '0 : node_q + 3'd1;
                    state_q <= (int'(node_q) == NUM_HL_NODES - 1) ? S_OL_MAC : S_HL_MAC;
                end
                S_OL_MAC: begin
                    acc_q <= acc_sum;
                    idx_q <= (int'(idx_q) == NUM_HL_NODES - 1) ? '0 : idx_q + 4'd1;
                    if (int'(idx_q) == NUM_HL_NODES - 1) state_q <= S_OL_FIN;
                end
                S_OL_FIN: begin
                    res_q[node_q] <= sat;
                    acc_q  <= '0;
                    node_q <= node_q + 3'd1;
                    if (int'(node_q) == NUM_OL_NODES - 1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_OL_MAC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Signed argmax; strict compare keeps the lowest index on ties.
    logic [2:0] best;
    always_comb begin
        best = '0;
        for (int k = 1; k < NUM_OL_NODES; k++)
            if ($signed(res_q[k]) > $signed(res_q[best])) best = 3'(k);
        LEDS = '0;
        if (done_q) LEDS[best] = 1'b1;
        LEDS[6] = busy_q;
        LEDS[7] = done_q;
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    logic [1:0]  digit;
    logic [15:0] disp;
    logic [3:0]  nibble;
    assign digit  = cnt_q[SS_REFRESH_BITS-1 -: 2];
    assign disp   = {regs_q[I_DBUG+1], regs_q[I_DBUG]};
    assign nibble = disp[{digit, 2'b00} +: 4];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q    <= '0;
            anodes_q <= 4'hF;
            segs_q   <= 8'hFF;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
            anodes_q <= ~(4'b0001 << digit);
            segs_q   <= ~{1'b0, hex7(nibble)};
        end
    end

    assign STALL       = 1'b0;
    assign ACK         = ack_q;
    assign ERR         = err_q;
    assign RDATA       = rdata_q;
    assign SS_ANODES   = anodes_q;
    assign SS_SEGMENTS = segs_q;
endmodule

// File: tb/tb_cortez_network_top.sv
// Directed bench for cortez_network_top: bus vector table, register load/readback,
// two inference runs, reset abort and the seven-segment scan.
module tb_cortez_network_top;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        CYC = 1'b0, STB = 1'b0, WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [7:0]  WDATA = '0;
  logic [0:0]  SEL = '0;
  logic        STALL, ACK, ERR;
  logic [7:0]  RDATA;
  logic [3:0]  SS_ANODES;
  logic [7:0]  SS_SEGMENTS, LEDS;

  cortez_network_top #(.SS_REFRESH_BITS(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .CYC(CYC), .STB(STB), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .SEL(SEL), .STALL(STALL), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
    .SS_ANODES(SS_ANODES), .SS_SEGMENTS(SS_SEGMENTS), .LEDS(LEDS)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] a(input int off);
    return 32'h3000_0000 + 32'(off * 4);
  endfunction

  task automatic bus(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                     input logic sel, output logic ack, output logic err, output logic [7:0] rd);
    @(negedge CLK);
    CYC = 1'b1; STB = 1'b1; WE = we; ADDR = addr; WDATA = wd; SEL = sel;
    @(posedge CLK); #1;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    ack = ACK; err = ERR; rd = RDATA;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    logic k, e;
    logic [7:0] r;
    bus(1'b1, a(off), d, 1'b1, k, e, r);
  endtask

  // Compares {ack, err, rdata} of a read against an ACKed response with exp data.
  task automatic rd_chk(input string name, input int off, input logic [7:0] exp);
    logic k, e;
    logic [7:0] r;
    bus(1'b0, a(off), 8'h00, 1'b1, k, e, r);
    check(name, {22'd0, k, e, r}, {22'd0, 1'b1, 1'b0, exp});
  endtask

  task automatic setup_model(input logic [7:0] hl_bias);
    for (int i = 6; i <= 14; i++) wr(i, 8'h20);
    for (int i = 16; i <= 51; i++) wr(i, 8'h08);
    for (int i = 52; i <= 55; i++) wr(i, hl_bias);
    for (int i = 56; i <= 67; i++) wr(i, (i < 60) ? 8'h20 : 8'h00);
    wr(68, 8'h00); wr(69, 8'h00); wr(70, 8'h10);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        sel;
    logic        exp_ack;
    logic        exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    logic k, e;
    logic [7:0] r;
    int cnt;
    logic [3:0] exp_an;
    logic [7:0] exp_seg [4];

    vecs[0]  = '{1'b0, 32'h3000_0004, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}; // status after reset
    vecs[1]  = '{1'b1, 32'h3000_0008, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 32'h3000_000C, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 32'h3000_0010, 8'h7E, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 32'h3000_0014, 8'h81, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 32'h3000_0008, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 32'h3000_000C, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[7]  = '{1'b0, 32'h3000_0010, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7E};
    vecs[8]  = '{1'b0, 32'h3000_0014, 8'h00, 1'b1, 1'b1, 1'b0, 8'h81};
    vecs[9]  = '{1'b1, 32'h3000_1010, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00}; // outside window
    vecs[10] = '{1'b0, 32'h3000_003C, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00}; // offset 0x0F
    vecs[11] = '{1'b1, 32'h3000_003C, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 32'h3000_0010, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7E}; // unchanged by vec 9
    vecs[13] = '{1'b1, 32'h3000_0014, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}; // SEL[0]=0
    vecs[14] = '{1'b0, 32'h3000_0014, 8'h00, 1'b1, 1'b1, 1'b0, 8'h81};
    vecs[15] = '{1'b1, 32'h3000_011C, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00}; // OL_RESULT_0 is RO
    vecs[16] = '{1'b0, 32'h3000_011C, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[17] = '{1'b0, 32'h3000_0128, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00}; // offset 0x4A
    vecs[18] = '{1'b0, 32'h3000_0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}; // CTRL reads 0
    vecs[19] = '{1'b1, 32'h3000_0004, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[20] = '{1'b0, 32'h3000_0004, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_leds", {24'd0, LEDS}, 32'h00);
    check("rst_anodes", {28'd0, SS_ANODES}, 32'hF);
    check("rst_segments", {24'd0, SS_SEGMENTS}, 32'hFF);
    check("rst_bus", {22'd0, ACK, ERR, RDATA}, 32'h0);
    check("stall", {31'd0, STALL}, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, k, e, r);
      check($sformatf("vec%0d_ack_err", i), {30'd0, k, e}, {30'd0, vecs[i].exp_ack, vecs[i].exp_err});
      if (!(vecs[i].we && vecs[i].exp_ack))
        check($sformatf("vec%0d_rdata", i), {24'd0, r}, {24'd0, vecs[i].exp_rd});
    end
    @(posedge CLK); #1;
    check("ack_single_pulse", {30'd0, ACK, ERR}, 32'h0);

    // Full parameter load and readback
    for (int i = 16; i <= 70; i++) wr(i, 8'(i * 7 + 3));
    for (int i = 16; i <= 70; i++) rd_chk($sformatf("readback_%0h", i), i, 8'(i * 7 + 3));
    wr(6, 8'h5A);
    rd_chk("grid0_idle_write", 6, 8'h5A);

    // Inference 1: hidden = 0x48 on every node
    setup_model(8'h00);
    wr(0, 8'h02);
    cnt = 0;
    while (LEDS[6] === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge CLK); #1;
    end
    check("busy_cycles_run1", cnt, 55);
    check("leds_run1", {24'd0, LEDS}, 32'h81);
    rd_chk("res0_run1", 71, 8'h7F);
    rd_chk("res1_run1", 72, 8'h00);
    rd_chk("res2_run1", 73, 8'h10);
    rd_chk("status_run1", 1, 8'h02);

    // Inference 2: saturating negative bias, ReLU clamps hidden to 0; bus traffic while busy
    setup_model(8'h80);
    wr(0, 8'h02);
    check("busy_after_start", {30'd0, LEDS[7:6]}, 32'h1);
    wr(6, 8'h00);
    rd_chk("status_busy", 1, 8'h01);
    wr(0, 8'h02);
    cnt = 3;
    while (LEDS[6] === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge CLK); #1;
    end
    check("busy_cycles_run2", cnt, 55);
    check("leds_run2", {24'd0, LEDS}, 32'h84);
    rd_chk("res0_run2", 71, 8'h00);
    rd_chk("res1_run2", 72, 8'h00);
    rd_chk("res2_run2", 73, 8'h10);
    rd_chk("grid0_busy_discard", 6, 8'h20);

    // Reset mid-inference
    wr(0, 8'h02);
    repeat (20) @(posedge CLK);
    #1;
    check("busy_before_abort", {30'd0, LEDS[7:6]}, 32'h1);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("abort_leds", {24'd0, LEDS}, 32'h00);
    check("abort_anodes", {28'd0, SS_ANODES}, 32'hF);
    check("abort_segments", {24'd0, SS_SEGMENTS}, 32'hFF);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    rd_chk("abort_status", 1, 8'h00);
    rd_chk("abort_res0", 71, 8'h00);
    rd_chk("abort_res2", 73, 8'h00);
    rd_chk("abort_grid0", 6, 8'h00);
    rd_chk("abort_dbug0", 2, 8'h00);

    // Seven-segment scan of 0x1234
    wr(2, 8'h34);
    wr(3, 8'h12);
    repeat (2) @(posedge CLK);
    #1;
    exp_seg[0] = 8'h99; exp_seg[1] = 8'hB0; exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      cnt = 0;
      while (SS_ANODES !== exp_an && cnt < 300) begin
        cnt++;
        @(posedge CLK); #1;
      end
      check($sformatf("scan_anode%0d", d), {28'd0, SS_ANODES}, {28'd0, exp_an});
      check($sformatf("scan_seg%0d", d), {24'd0, SS_SEGMENTS}, {24'd0, exp_seg[d]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
